// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cal_pkg
//  Description : Shared constants and enumerations for the cal_* lane
//                expander / comparator stages.
//  Revision    : 1.0  initial release
// ============================================================================
package cal_pkg;

    localparam int DATA_W = 8;
    localparam int LANES  = 3;
    localparam int IDX_W  = 2;

    // Index value with no corresponding lane; produces an all-zero word.
    localparam logic [IDX_W-1:0] IDX_INVALID = 2'd3;

    typedef enum logic {
        FILL_UNPOOL   = 1'b0,
        FILL_UPSAMPLE = 1'b1
    } fill_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } exp_state_e;

endpackage
`default_nettype wire

// File: rtl/cal_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : cal_skid_buf
//  Description : Two-entry valid/ready skid buffer (output register plus skid
//                register). Upstream ready is fully registered and equals
//                "skid entry empty", so it never depends on i_m_ready within
//                the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module cal_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    logic             r_out_valid_q;
    logic             w_out_valid_d;
    logic [WIDTH-1:0] r_out_data_q;
    logic [WIDTH-1:0] w_out_data_d;
    logic             r_skid_valid_q;
    logic             w_skid_valid_d;
    logic [WIDTH-1:0] r_skid_data_q;
    logic [WIDTH-1:0] w_skid_data_d;
    logic             r_ready_q;
    logic             w_ready_d;
    logic             w_accept;
    logic             w_out_free;

    assign w_accept   = i_s_valid && r_ready_q;
    // Output slot can take a new entry when empty or being drained this cycle.
    assign w_out_free = !r_out_valid_q || i_m_ready;

    // Next-state of both entries: skid drains into the output register first,
    // new beats land in the output slot when free, otherwise in the skid slot.
    always_comb begin
        w_out_valid_d  = r_out_valid_q;
        w_out_data_d   = r_out_data_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_data_d  = r_skid_data_q;
        if (w_out_free) begin
            if (r_skid_valid_q) begin
                w_out_valid_d  = 1'b1;
                w_out_data_d   = r_skid_data_q;
                w_skid_valid_d = w_accept;
                if (w_accept) begin
                    w_skid_data_d = i_s_data;
                end
            end else begin
                w_out_valid_d = w_accept;
                if (w_accept) begin
                    w_out_data_d = i_s_data;
                end
            end
        end else if (w_accept) begin
            w_skid_valid_d = 1'b1;
            w_skid_data_d  = i_s_data;
        end
        w_ready_d = !w_skid_valid_d;
    end

    // Entry registers; ready stays low during reset and rises one cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_q  <= 1'b0;
            r_out_data_q   <= '0;
            r_skid_valid_q <= 1'b0;
            r_skid_data_q  <= '0;
            r_ready_q      <= 1'b0;
        end else begin
            r_out_valid_q  <= w_out_valid_d;
            r_out_data_q   <= w_out_data_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_data_q  <= w_skid_data_d;
            r_ready_q      <= w_ready_d;
        end
    end

    assign o_s_ready = r_ready_q;
    assign o_m_valid = r_out_valid_q;
    assign o_m_data  = r_out_data_q;

endmodule
`default_nettype wire

// File: rtl/cal_expander_x3.sv
`default_nettype none
// ============================================================================
//  Module      : cal_expander_x3
//  Description : Rebuilds a 3-lane word from (max value, lane index) beats,
//                either unpooling (value in one lane) or upsampling (value in
//                all lanes). Tags the last beat of each frame, counts emitted
//                frames and flags illegal lane indices. LANES is fixed at 3.
//  Revision    : 1.0  initial release
// ============================================================================
module cal_expander_x3
    import cal_pkg::*;
#(
    parameter int DATA_W = cal_pkg::DATA_W,
    parameter int LANES  = cal_pkg::LANES,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_fill,
    input  logic [CNT_W-1:0]        cfg_len,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic [IDX_W-1:0]        s_index,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*DATA_W-1:0] m_data,
    output logic                    m_last,
    output logic                    err_index,
    output logic [CNT_W-1:0]        frame_cnt
);

    localparam int PAY_W = LANES * DATA_W + 1;

    fill_mode_e              w_fill;
    logic                    w_accept;
    logic                    w_emit;
    logic [LANES*DATA_W-1:0] w_word;
    logic [CNT_W-1:0]        w_len_new;
    logic                    w_last;
    logic [PAY_W-1:0]        w_buf_data;

    exp_state_e              r_state_q;
    exp_state_e              w_state_d;
    logic [CNT_W-1:0]        r_len_q;
    logic [CNT_W-1:0]        w_len_d;
    logic [CNT_W-1:0]        r_cnt_q;
    logic [CNT_W-1:0]        w_cnt_d;
    logic                    r_err_q;
    logic                    w_err_d;
    logic [CNT_W-1:0]        r_frame_q;
    logic [CNT_W-1:0]        w_frame_d;

    assign w_fill    = fill_mode_e'(cfg_fill);
    assign w_accept  = s_valid && s_ready;
    assign w_emit    = m_valid && m_ready;
    // A zero length would never terminate a frame; treat it as one beat.
    assign w_len_new = (cfg_len == '0) ? CNT_W'(1) : cfg_len;

    // Word build from the accepted beat; an illegal index yields all zeros.
    always_comb begin
        w_word = '0;
        if (s_index != IDX_INVALID) begin
            for (int k = 0; k < LANES; k++) begin
                if ((w_fill == FILL_UPSAMPLE) || (s_index == IDX_W'(k))) begin
                    w_word[k*DATA_W +: DATA_W] = s_data;
                end
            end
        end
    end

    // Frame FSM: latches the length on the first beat, tags the final beat.
    always_comb begin
        w_state_d = r_state_q;
        w_len_d   = r_len_q;
        w_cnt_d   = r_cnt_q;
        w_last    = 1'b0;
        if (w_accept) begin
            case (r_state_q)
                IDLE: begin
                    w_len_d = w_len_new;
                    w_cnt_d = CNT_W'(1);
                    if (w_len_new == CNT_W'(1)) begin
                        w_last = 1'b1;
                    end else begin
                        w_state_d = RUN;
                    end
                end
                RUN: begin
                    if (r_cnt_q == r_len_q - CNT_W'(1)) begin
                        w_last    = 1'b1;
                        w_cnt_d   = '0;
                        w_state_d = IDLE;
                    end else begin
                        w_cnt_d = r_cnt_q + CNT_W'(1);
                    end
                end
                default: w_state_d = IDLE;
            endcase
        end
    end

    // Sticky index error and emitted-frame counter.
    always_comb begin
        w_err_d   = r_err_q;
        w_frame_d = r_frame_q;
        if (w_accept && (s_index == IDX_INVALID)) begin
            w_err_d = 1'b1;
        end
        if (w_emit && m_last) begin
            w_frame_d = r_frame_q + CNT_W'(1);
        end
    end

    // State registers for the FSM, error flag and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_len_q   <= CNT_W'(1);
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
            r_frame_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_len_q   <= w_len_d;
            r_cnt_q   <= w_cnt_d;
            r_err_q   <= w_err_d;
            r_frame_q <= w_frame_d;
        end
    end

    cal_skid_buf #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_s_valid (s_valid),
        .o_s_ready (s_ready),
        .i_s_data  ({w_last, w_word}),
        .o_m_valid (m_valid),
        .i_m_ready (m_ready),
        .o_m_data  (w_buf_data)
    );

    assign m_last    = w_buf_data[PAY_W-1];
    assign m_data    = w_buf_data[PAY_W-2:0];
    assign err_index = r_err_q;
    assign frame_cnt = r_frame_q;

endmodule
`default_nettype wire

// File: doc/cal_expander_x3.md
Name: cal_expander_x3

Overview:
- Inverse of the 3-lane argmax comparator stage: consumes a stream of (max value, lane index) pairs and rebuilds a 3-lane 24-bit word.
- Sits on the decode/upsample path of the YOLO datapath, feeding max-unpool or nearest-upsample consumers.
- Streaming valid/ready on both sides, 1-cycle latency, full throughput.
- Frame counter tags the last beat of each row and flags illegal lane indices.

Parameters:
- DATA_W, 8, lane width in bits.
- LANES, 3, number of output lanes; fixed at 3, must not be overridden.
- CNT_W, 16, width of the beat and frame counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_fill  in  1  fill mode. 0 = unpool: zeros in the non-selected lanes. 1 = upsample: value replicated into all lanes.
- cfg_len  in  CNT_W  beats per frame; sampled on the first beat of each frame.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input ready.
- s_data  in  DATA_W  max value.
- s_index  in  2  lane index, legal values 0..2.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_data  out  LANES*DATA_W  lane k occupies bits [8k+7:8k].
- m_last  out  1  final beat of the frame.
- err_index  out  1  sticky; set when s_index==3 is accepted.
- frame_cnt  out  CNT_W  completed frames; wraps at 2^CNT_W.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. No other reset.
- Reset values:
  - m_valid=0, m_data=0, m_last=0, err_index=0, frame_cnt=0, s_ready=0.
  - Both buffer entries empty; beat counter = 0; FSM in IDLE.
  - s_ready rises in the first cycle after rst deasserts.
- Reset mid-frame: in-flight beats are discarded, not flushed, and the partial frame is not counted.
- Acceptance: a beat is accepted when s_valid && s_ready; emitted when m_valid && m_ready.
- Word build, done on acceptance from registered inputs:
  - cfg_fill=0: lane[s_index]=s_data, other lanes 0.
  - cfg_fill=1: all lanes = s_data.
  - s_index==3, either mode: m_data=0 and err_index is set. err_index stays set until rst.
  - cfg_fill is sampled per beat.
- Buffering: two-entry skid buffer (output register plus skid register).
  - Latency: accepted at edge N, m_valid is high after edge N.
  - s_ready is registered and equals "skid entry empty". It never depends combinationally on m_ready.
  - With m_ready held high, one beat per cycle is sustained.
  - When m_ready is low and both entries are full, s_ready=0. No beat is lost or duplicated.
  - m_data and m_last are held stable while m_valid && !m_ready.
- Frame FSM (states IDLE, RUN), advanced on input acceptance:
  - IDLE, beat accepted: len_q <= (cfg_len==0 ? 1 : cfg_len); cnt <= 1. If len_q is 1, the beat is last and the FSM stays in IDLE; otherwise go to RUN.
  - RUN, beat accepted: cnt++. When cnt == len_q-1 before the increment, the beat is tagged last, cnt <= 0, go to IDLE.
  - frame_cnt increments when a last-tagged beat is emitted on the m side, not when it is accepted.
  - Changes to cfg_len while in RUN are ignored until the next frame.
- Simultaneous events:
  - Emit and accept in the same cycle with one entry occupied: occupancy stays 1.
  - rst wins over any handshake.

Decomposition:
- Package cal_pkg holds:
  - constants DATA_W=8, LANES=3, IDX_W=2, IDX_INVALID=2'd3;
  - enum fill_mode_e {FILL_UNPOOL, FILL_UPSAMPLE};
  - enum exp_state_e {IDLE, RUN}.
- Sub-module cal_skid_buf: parameterised width, 2-entry valid/ready skid buffer, synchronous active-high rst. Instantiated once with payload {m_last, m_data}. Reusable by other cal_* stages.

Test Plan:
- Unpool basic: cfg_fill=0, cfg_len=3, m_ready=1, inputs (0xA5,0),(0x3C,1),(0x7F,2) -> m_data 0x0000A5, 0x003C00, 0x7F0000 on consecutive cycles; m_last only on the third; frame_cnt=1.
- Upsample: cfg_fill=1, input (0x12,1) -> m_data 0x121212; err_index stays 0.
- Backpressure: m_ready=0 for 4 cycles, 5 beats offered -> exactly 2 accepted, s_ready=0 afterwards, m_data stable. Release m_ready -> all 5 beats emerge in order, no gaps once flowing.
- Illegal index: input (0xFF,3) -> m_data 0x000000, err_index=1 and held through 10 further legal beats; cleared only by rst.
- Length edges: cfg_len=0 -> every beat has m_last=1. cfg_len changed from 4 to 2 after beat 2 -> m_last on beat 4; next frame uses 2. 2^16 frames -> frame_cnt wraps to 0.
- Reset mid-frame: rst asserted with 2 beats buffered in a 5-beat frame -> next cycle m_valid=0 and s_ready=0. After release, a fresh 5-beat frame gives m_last on its 5th beat; frame_cnt is unchanged by the aborted frame.
